serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub.sv | 105 ++++++++++
 tb/tb_serial_addsub.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder step per clock, LSB first.
// Define OVERFLOW_FLAG_EN to build the signed-overflow flag; otherwise OV is tied low.
module serial_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] F,
    output logic             C2,
    output logic             OV
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StFin  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_f;
    logic             r_c2;

    logic w_sum;
    logic w_cout;
    logic w_last;

    assign w_sum  = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_cout = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    assign w_last = (r_state == StRun) && (r_cnt == LastCnt);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_f     <= '0;
            r_c2    <= 1'b0;
        end else begin
            case (r_state)
                StRun: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= {w_sum, r_res[WIDTH-1:1]};
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    // The final sum bit is merged straight into F, not via r_res.
                    if (w_last) begin
                        r_state <= StFin;
                        r_f     <= {w_sum, r_res[WIDTH-1:1]};
                        r_c2    <= w_cout;
                    end
                end
                default: begin
                    if (START) begin
                        r_state <= StRun;
                        r_a     <= A;
                        r_b     <= B ^ {WIDTH{SUB}};
                        r_carry <= SUB;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= StIdle;
                    end
                end
            endcase
        end
    end

`ifdef OVERFLOW_FLAG_EN
    logic r_ov;

    // On the last step r_carry is the carry into the MSB and w_cout the carry out of it.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_ov <= 1'b0;
        end else if (w_last) begin
            r_ov <= r_carry ^ w_cout;
        end
    end

    assign OV = r_ov;
`else
    assign OV = 1'b0;
`endif

    assign BUSY = (r_state == StRun);
    assign DONE = (r_state == StFin);
    assign F    = r_f;
    assign C2   = r_c2;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboarded bench for serial_addsub (WIDTH=8); honours OVERFLOW_FLAG_EN for OV expectations.
module tb_serial_addsub;

    localparam int unsigned W = 8;

    logic         CLK   = 1'b0;
    logic         RST_N = 1'b0;
    logic         START = 1'b0;
    logic         SUB   = 1'b0;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] F;
    logic         C2;
    logic         OV;

    serial_addsub #(.WIDTH(W)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .START(START),
        .SUB  (SUB),
        .A    (A),
        .B    (B),
        .BUSY (BUSY),
        .DONE (DONE),
        .F    (F),
        .C2   (C2),
        .OV   (OV)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [W-1:0] f;
        logic         c2;
        logic         ov;
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   errors     = 0;
    int   done_count = 0;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t         r;
        logic [W-1:0] bm;
        logic [W:0]   s;
        bm   = b ^ {W{sub}};
        s    = {1'b0, a} + {1'b0, bm} + {{W{1'b0}}, sub};
        r.f  = s[W-1:0];
        r.c2 = s[W];
`ifdef OVERFLOW_FLAG_EN
        r.ov = (a[W-1] == bm[W-1]) && (s[W-1] != a[W-1]);
`else
        r.ov = 1'b0;
`endif
        return r;
    endfunction

    // Output monitor: every DONE pops one expected result.
    always @(negedge CLK) begin
        if (DONE) begin
            exp_t e;
            done_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got F=%0h C2=%0b OV=%0b with empty scoreboard",
                         F, C2, OV);
            end else begin
                e = exp_q.pop_front();
                if ({F, C2, OV} !== {e.f, e.c2, e.ov}) begin
                    errors++;
                    $display("FAIL result: got F=%0h C2=%0b OV=%0b expected F=%0h C2=%0b OV=%0b",
                             F, C2, OV, e.f, e.c2, e.ov);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          output int lat, output int busy_n, output logic f_stable,
                          output logic done_after);
        logic [W-1:0] f0;
        exp_q.push_back(model(a, b, sub));
        @(posedge CLK); #1;
        A = a; B = b; SUB = sub; START = 1'b1;
        f0 = F; lat = 0; busy_n = 0; f_stable = 1'b1;
        do begin
            @(posedge CLK); #1;
            START = 1'b0;
            lat++;
            if (BUSY) busy_n++;
            if (!DONE && F !== f0) f_stable = 1'b0;
        end while (!DONE && lat < 200);
        @(posedge CLK); #1;
        done_after = DONE;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; START = 1'b1; A = 8'h11; B = 8'h22;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", DONE); end
        checks++; if (F !== '0) begin errors++; $display("FAIL reset_f: got %0h expected 0", F); end
        checks++; if (C2 !== 1'b0) begin errors++; $display("FAIL reset_c2: got %b expected 0", C2); end
        checks++; if (OV !== 1'b0) begin errors++; $display("FAIL reset_ov: got %b expected 0", OV); end
        RST_N = 1'b1; START = 1'b0;
        @(posedge CLK); #1;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_start_ignored: got BUSY=%b expected 0", BUSY); end
    endtask

    task automatic test_vectors(input string name, input logic sub);
        logic [W-1:0] va[4];
        logic [W-1:0] vb[4];
        int           lat, busy_n;
        logic         stable, dafter;
        if (!sub) begin
            va = '{8'h05, 8'hFF, 8'h7F, 8'h3C};
            vb = '{8'h03, 8'h01, 8'h01, 8'hC4};
        end else begin
            va = '{8'h03, 8'h80, 8'h10, 8'h00};
            vb = '{8'h05, 8'h01, 8'h10, 8'h01};
        end
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], sub, lat, busy_n, stable, dafter);
            checks++; if (lat != int'(W + 1)) begin errors++; $display("FAIL %s_latency[%0d]: got %0d expected %0d", name, i, lat, W + 1); end
            checks++; if (busy_n != int'(W)) begin errors++; $display("FAIL %s_busy_cycles[%0d]: got %0d expected %0d", name, i, busy_n, W); end
            checks++; if (stable !== 1'b1) begin errors++; $display("FAIL %s_f_hold[%0d]: got toggling expected stable", name, i); end
            checks++; if (dafter !== 1'b0) begin errors++; $display("FAIL %s_done_width[%0d]: got DONE=%b after pulse expected 0", name, i, dafter); end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL %s_pending: got %0d expected 0", name, exp_q.size()); end
    endtask

    task automatic test_add();
        test_vectors("add", 1'b0);
    endtask

    task automatic test_sub();
        test_vectors("sub", 1'b1);
    endtask

    task automatic test_ignore_in_run();
        int d0;
        d0 = done_count;
        exp_q.push_back(model(8'h10, 8'h10, 1'b0));
        @(posedge CLK); #1;
        A = 8'h10; B = 8'h10; SUB = 1'b0; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        @(posedge CLK); #1;
        A = 8'hAA; B = 8'h55; SUB = 1'b1; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (2 * W + 6) @(posedge CLK);
        #1;
        checks++; if (done_count - d0 != 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", done_count - d0); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL ignore_busy: got %b expected 0", BUSY); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ignore_pending: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_abort();
        int   lat, busy_n, d0;
        logic stable, dafter;
        run_op(8'h7F, 8'h01, 1'b0, lat, busy_n, stable, dafter);
        @(posedge CLK); #1;
        A = 8'h12; B = 8'h34; SUB = 1'b0; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        // Reset lands during RUN cycle 4, with a START that must be ignored.
        RST_N = 1'b0; START = 1'b1; A = 8'h01; B = 8'h01;
        @(posedge CLK); #1;
        RST_N = 1'b1; START = 1'b0;
        d0 = done_count;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", BUSY); end
        checks++; if (F !== '0) begin errors++; $display("FAIL abort_f: got %0h expected 0", F); end
        checks++; if (C2 !== 1'b0) begin errors++; $display("FAIL abort_c2: got %b expected 0", C2); end
        checks++; if (OV !== 1'b0) begin errors++; $display("FAIL abort_ov: got %b expected 0", OV); end
        repeat (W + 4) @(posedge CLK);
        #1;
        checks++; if (done_count != d0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", done_count - d0); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL abort_idle: got BUSY=%b expected 0", BUSY); end
    endtask

    task automatic test_back_to_back();
        int n1, n2, d0;
        d0 = done_count;
        exp_q.push_back(model(8'h01, 8'h02, 1'b0));
        exp_q.push_back(model(8'h04, 8'h04, 1'b0));
        @(posedge CLK); #1;
        A = 8'h01; B = 8'h02; SUB = 1'b0; START = 1'b1;
        n1 = 0;
        do begin
            @(posedge CLK); #1;
            n1++;
        end while (!DONE && n1 < 100);
        A = 8'h04; B = 8'h04;
        @(posedge CLK); #1;
        START = 1'b0;
        n2 = 1;
        while (!DONE && n2 < 100) begin
            @(posedge CLK); #1;
            n2++;
        end
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (n1 != int'(W + 1)) begin errors++; $display("FAIL b2b_first_latency: got %0d expected %0d", n1, W + 1); end
        checks++; if (n2 != int'(W + 1)) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", n2, W + 1); end
        checks++; if (done_count - d0 != 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_count - d0); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_random();
        int           lat, busy_n;
        logic         stable, dafter;
        logic [W-1:0] a, b;
        logic         s;
        for (int i = 0; i < 10; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            s = 1'($urandom_range(0, 1));
            run_op(a, b, s, lat, busy_n, stable, dafter);
            checks++; if (lat != int'(W + 1)) begin errors++; $display("FAIL random_latency[%0d]: got %0d expected %0d", i, lat, W + 1); end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL random_pending: got %0d expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_ignore_in_run();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
